// File: rtl/fp_lane_packer.sv
// fp_lane_packer: packs scalar FP results into 32-bit lane words.
// FP32 passes whole; bf16 pairs fill hi then lo, queued in a FIFO.
package fp_lane_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } fp_lanes_t;

  typedef union packed {
    logic [31:0] w;
    fp_lanes_t   lanes;
  } fp_vec_u;

  typedef struct packed {
    fp_vec_u     data;
    fp_fmt_e     fmt;
    logic [1:0]  mask;
    logic        last;
  } pk_ent_t;

endpackage

module fp_lane_packer
  import fp_lane_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_fmt,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_fmt,
  output logic [1:0]  out_lane_mask,
  output logic        out_last,
  output logic        partial_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pk_state_e;

  pk_state_e         state;
  pk_state_e         nxt_state;
  logic [15:0]       hold_reg;
  logic [15:0]       nxt_hold;
  pk_ent_t           mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [CW-1:0]     need;
  logic [1:0]        push_n;
  pk_ent_t           ent0;
  pk_ent_t           ent1;
  pk_ent_t           head;
  logic              in_fire;
  logic              out_fire;
  logic              is_half;
  logic              is_f16;

  // a held hi lane may need two slots (flush + new word)
  assign free     = CW'(DEPTH) - count;
  assign need     = (state == HALF) ? CW'(2) : CW'(1);
  assign in_ready = !rst && (free >= need);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_half  = (state == HALF);
  assign is_f16   = in_fmt;

  // next packer state and the 0..2 entries to enqueue
  always_comb begin
    push_n    = 2'd0;
    ent0      = '0;
    ent1      = '0;
    nxt_state = state;
    nxt_hold  = hold_reg;
    if (in_fire) begin
      unique case (1'b1)
        (!is_half && !is_f16): begin
          push_n    = 2'd1;
          ent0.data = in_data;
          ent0.fmt  = FP32;
          ent0.mask = 2'b11;
          ent0.last = in_last;
        end
        (!is_half && is_f16 && !in_last): begin
          nxt_state = HALF;
          nxt_hold  = in_data[15:0];
        end
        (!is_half && is_f16 && in_last): begin
          push_n             = 2'd1;
          ent0.data.lanes.hi = in_data[15:0];
          ent0.data.lanes.lo = 16'h0000;
          ent0.fmt           = FP16;
          ent0.mask          = 2'b10;
          ent0.last          = 1'b1;
        end
        (is_half && is_f16): begin
          push_n             = 2'd1;
          ent0.data.lanes.hi = hold_reg;
          ent0.data.lanes.lo = in_data[15:0];
          ent0.fmt           = FP16;
          ent0.mask          = 2'b11;
          ent0.last          = in_last;
          nxt_state          = EMPTY;
          nxt_hold           = 16'h0000;
        end
        (is_half && !is_f16): begin
          push_n             = 2'd2;
          ent0.data.lanes.hi = hold_reg;
          ent0.data.lanes.lo = 16'h0000;
          ent0.fmt           = FP16;
          ent0.mask          = 2'b10;
          ent0.last          = 1'b0;
          ent1.data          = in_data;
          ent1.fmt           = FP32;
          ent1.mask          = 2'b11;
          ent1.last          = in_last;
          nxt_state          = EMPTY;
          nxt_hold           = 16'h0000;
        end
        default: begin
          push_n = 2'd0;
        end
      endcase
    end
  end

  // packer state, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      hold_reg <= 16'h0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= nxt_state;
      hold_reg <= nxt_hold;
      wr_ptr   <= wr_ptr + AW'(push_n);
      rd_ptr   <= rd_ptr + AW'(out_fire);
      count    <= count + CW'(push_n) - CW'(out_fire);
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem[wr_ptr] <= ent0;
    end
    if (push_n == 2'd2) begin
      mem[wr_ptr + AW'(1)] <= ent1;
    end
  end

  assign out_valid       = (count != '0);
  assign head            = out_valid ? mem[rd_ptr] : '0;
  assign out_data        = head.data.w;
  assign out_fmt         = head.fmt;
  assign out_lane_mask   = head.mask;
  assign out_last        = head.last;
  assign partial_pending = is_half;

endmodule

// File: tb/tb_fp_lane_packer.sv
// tb_fp_lane_packer: directed scenarios plus randomized
// traffic checked against a queue-based packing model.
module tb_fp_lane_packer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        fmt;
    logic [1:0]  mask;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_fmt;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_fmt;
  logic [1:0]  out_lane_mask;
  logic        out_last;
  logic        partial_pending;

  int checks   = 0;
  int failures = 0;

  word_t       exp_q[$];
  bit          m_half;
  logic [15:0] m_hold;

  fp_lane_packer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_fmt          (in_fmt),
    .in_data         (in_data),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_fmt         (out_fmt),
    .out_lane_mask   (out_lane_mask),
    .out_last        (out_last),
    .partial_pending (partial_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit f,
                        input logic [31:0] d, input bit l);
    in_valid = v;
    in_fmt   = f;
    in_data  = d;
    in_last  = l;
  endtask

  // packing rules applied to one accepted element
  function automatic void model_accept(input bit f,
                                       input logic [31:0] d,
                                       input bit l);
    word_t w;
    if (!f) begin
      if (m_half) begin
        w = '{data: {m_hold, 16'h0}, fmt: 1'b1,
              mask: 2'b10, last: 1'b0};
        exp_q.push_back(w);
        m_half = 0;
      end
      w = '{data: d, fmt: 1'b0, mask: 2'b11, last: l};
      exp_q.push_back(w);
    end else if (m_half) begin
      w = '{data: {m_hold, d[15:0]}, fmt: 1'b1,
            mask: 2'b11, last: l};
      exp_q.push_back(w);
      m_half = 0;
    end else if (l) begin
      w = '{data: {d[15:0], 16'h0}, fmt: 1'b1,
            mask: 2'b10, last: 1'b1};
      exp_q.push_back(w);
    end else begin
      m_half = 1;
      m_hold = d[15:0];
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 32'h0, 0);
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    m_half = 0;
    m_hold = '0;
    exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 0, 32'hDEADBEEF, 1);
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if ({out_valid, out_data, out_fmt, out_lane_mask,
         out_last, partial_pending} !== 37'h0) begin
      failures++;
      $display("FAIL reset_outs got v=%b d=%h f=%b m=%b l=%b p=%b exp zeros",
               out_valid, out_data, out_fmt, out_lane_mask,
               out_last, partial_pending);
    end
    set_in(0, 0, 32'h0, 0);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
    tick();
  endtask

  task automatic test_fp32_single();
    do_reset();
    out_ready = 1'b1;
    set_in(1, 0, 32'h3F800000, 1);
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({out_valid, out_data, out_fmt, out_lane_mask, out_last} !==
        {1'b1, 32'h3F800000, 1'b0, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL fp32_word got v=%b d=%h f=%b m=%b l=%b exp 1 3f800000 0 11 1",
               out_valid, out_data, out_fmt, out_lane_mask, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fp32_one_cycle got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_fp16_pair();
    do_reset();
    out_ready = 1'b1;
    set_in(1, 1, 32'hABCD3F80, 0);
    tick();
    checks++;
    if ({partial_pending, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL pair_hold got p=%b v=%b exp p=1 v=0",
               partial_pending, out_valid);
    end
    set_in(1, 1, 32'h99994000, 1);
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({partial_pending, out_valid, out_data, out_fmt,
         out_lane_mask, out_last} !==
        {1'b0, 1'b1, 32'h3F804000, 1'b1, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL pair_word got p=%b v=%b d=%h f=%b m=%b l=%b exp 0 1 3f804000 1 11 1",
               partial_pending, out_valid, out_data, out_fmt,
               out_lane_mask, out_last);
    end
    tick();
  endtask

  task automatic test_odd_group();
    do_reset();
    out_ready = 1'b1;
    set_in(1, 1, 32'h00003F80, 0);
    tick();
    set_in(1, 1, 32'h00004000, 0);
    tick();
    set_in(1, 1, 32'hFFFF4040, 1);
    checks++;
    if ({out_valid, out_data, out_lane_mask, out_last} !==
        {1'b1, 32'h3F804000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL odd_first got v=%b d=%h m=%b l=%b exp 1 3f804000 11 0",
               out_valid, out_data, out_lane_mask, out_last);
    end
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({out_valid, out_data, out_fmt, out_lane_mask, out_last} !==
        {1'b1, 32'h40400000, 1'b1, 2'b10, 1'b1}) begin
      failures++;
      $display("FAIL odd_second got v=%b d=%h f=%b m=%b l=%b exp 1 40400000 1 10 1",
               out_valid, out_data, out_fmt, out_lane_mask, out_last);
    end
    tick();
  endtask

  task automatic test_fmt_switch();
    do_reset();
    out_ready = 1'b1;
    set_in(1, 1, 32'h1111BF80, 0);
    tick();
    set_in(1, 0, 32'h40490FDB, 1);
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({out_valid, out_data, out_fmt, out_lane_mask, out_last} !==
        {1'b1, 32'hBF800000, 1'b1, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL switch_flush got v=%b d=%h f=%b m=%b l=%b exp 1 bf800000 1 10 0",
               out_valid, out_data, out_fmt, out_lane_mask, out_last);
    end
    tick();
    checks++;
    if ({out_valid, out_data, out_fmt, out_lane_mask, out_last} !==
        {1'b1, 32'h40490FDB, 1'b0, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL switch_fp32 got v=%b d=%h f=%b m=%b l=%b exp 1 40490fdb 0 11 1",
               out_valid, out_data, out_fmt, out_lane_mask, out_last);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int acc;
    int bad_stable;
    acc = 0;
    bad_stable = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 32'hA0000000 + i, 0);
      if (out_valid && (out_data !== 32'hA0000000))
        bad_stable++;
      if (in_ready) acc++;
      tick();
    end
    set_in(0, 0, 32'h0, 0);
    checks++;
    if (acc != DEPTH || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got acc=%0d rdy=%b exp acc=%0d rdy=0",
               acc, in_ready, DEPTH);
    end
    checks++;
    if (bad_stable != 0) begin
      failures++;
      $display("FAIL bp_stable got changes=%0d exp=0", bad_stable);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_comb_path got=%b exp=0", in_ready);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0000000 + k) begin
        failures++;
        $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h",
                 k, out_valid, out_data, 32'hA0000000 + k);
      end
      tick();
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_return got=%b exp=1", in_ready);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    set_in(1, 0, 32'h11111111, 0);
    tick();
    set_in(1, 0, 32'h22222222, 0);
    tick();
    set_in(1, 1, 32'h00001234, 0);
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({partial_pending, out_valid} !== 2'b11) begin
      failures++;
      $display("FAIL mid_setup got p=%b v=%b exp 1 1",
               partial_pending, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({partial_pending, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL mid_cleared got p=%b v=%b exp 0 0",
               partial_pending, out_valid);
    end
    out_ready = 1'b1;
    set_in(1, 1, 32'h00005555, 0);
    tick();
    set_in(1, 1, 32'h00006666, 1);
    tick();
    set_in(0, 0, 32'h0, 0);
    checks++;
    if ({out_valid, out_data, out_lane_mask} !==
        {1'b1, 32'h55556666, 2'b11}) begin
      failures++;
      $display("FAIL mid_fresh got v=%b d=%h m=%b exp 1 55556666 11",
               out_valid, out_data, out_lane_mask);
    end
    tick();
  endtask

  task automatic run_model(input int ncyc, input bit stress);
    word_t w;
    bit    exp_rdy;
    bit    ofire;
    bit    ifire;
    int    need;
    int    bad_rdy;
    int    bad_out;
    int    bad_pp;
    bad_rdy = 0;
    bad_out = 0;
    bad_pp  = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      set_in(stress ? 1'b1 : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 1), $urandom,
             $urandom_range(0, 2) == 0);
      out_ready = stress ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      need = m_half ? 2 : 1;
      exp_rdy = (DEPTH - exp_q.size()) >= need;
      if (in_ready !== exp_rdy || (stress && !in_ready)) bad_rdy++;
      if (out_valid !== (exp_q.size() != 0)) bad_out++;
      if (exp_q.size() != 0) begin
        w = exp_q[0];
        if ({out_data, out_fmt, out_lane_mask, out_last} !== w)
          bad_out++;
      end
      if (partial_pending !== m_half) bad_pp++;
      ofire = (exp_q.size() != 0) && out_ready;
      ifire = in_valid && exp_rdy;
      if (ofire) void'(exp_q.pop_front());
      if (ifire) model_accept(in_fmt, in_data, in_last);
      tick();
    end
    set_in(0, 0, 32'h0, 0);
    checks++;
    if (bad_rdy != 0) begin
      failures++;
      $display("FAIL model_in_ready stress=%0d got errs=%0d exp=0",
               stress, bad_rdy);
    end
    checks++;
    if (bad_out != 0) begin
      failures++;
      $display("FAIL model_out_words stress=%0d got errs=%0d exp=0",
               stress, bad_out);
    end
    checks++;
    if (bad_pp != 0) begin
      failures++;
      $display("FAIL model_partial stress=%0d got errs=%0d exp=0",
               stress, bad_pp);
    end
  endtask

  task automatic test_random();
    run_model(600, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_model(200, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    set_in(0, 0, 32'h0, 0);
    test_reset();
    test_fp32_single();
    test_fp16_pair();
    test_odd_group();
    test_fmt_switch();
    test_backpressure();
    test_reset_midstream();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_lane_packer.md
Name: fp_lane_packer

Overview:
- Result-side writer for the packed vector word: collects a stream of scalar FP results and packs them into 32-bit fp_vec_u words for writeback.
- FP32 results pass through as whole words. FP16 (bf16) results are paired into the hi lane, then the lo lane.
- Sits between the FPALL datapath output and the result writeback port.
- Valid/ready on both sides, with an internal output FIFO for decoupling.

Parameters:
- DEPTH, 4, output FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when in_valid & in_ready
- in_fmt  in  1  fp_fmt_e: FP32=0, FP16=1
- in_data  in  32  FP32: full word; FP16: bf16 in [15:0], [31:16] ignored
- in_last  in  1  last element of the current result group
- out_valid  out  1  packed word available
- out_ready  in  1  downstream accepts the word
- out_data  out  32  packed word; FP16 pairs as lanes.hi, lanes.lo
- out_fmt  out  1  fp_fmt_e of the word
- out_lane_mask  out  2  [1]=hi lane valid, [0]=lo lane valid; FP32 words always 2'b11
- out_last  out  1  word holds the group's last element
- partial_pending  out  1  a hi-lane bf16 is held waiting for its pair

Behaviour:
- Packer state:
  - EMPTY: no bf16 held.
  - HALF: hold_reg[15:0] contains a hi-lane bf16.
- Input accept:
  - in_ready = !rst & (free >= (state==HALF ? 2 : 1)).
  - free = DEPTH - count.
  - in_ready depends only on registered state/count; no combinational path from out_ready or in_* to in_ready.
- Accepted element, by state and format:
  - EMPTY, FP32: push {data, FP32, 2'b11, in_last}; stay EMPTY.
  - EMPTY, FP16, !in_last: hold_reg <= data[15:0]; go to HALF; no push.
  - EMPTY, FP16, in_last: push {data[15:0],16'h0000}, FP16, mask 2'b10, last=1; stay EMPTY.
  - HALF, FP16: push {hold_reg, data[15:0]}, FP16, mask 2'b11, last=in_last; go to EMPTY.
  - HALF, FP32 (format switch): in the same cycle, push two entries in order:
    - flush word {hold_reg,16'h0}, FP16, mask 2'b10, last=0;
    - then {data, FP32, 2'b11, in_last}.
    - Go to EMPTY.
- Unused lanes and ignored input bits are written as zero, never left stale.
- FIFO:
  - Circular buffer with wrapping wr/rd pointers and count 0..DEPTH.
  - Push of 0, 1 or 2 entries and pop of 0 or 1 may happen in the same cycle; count += pushes - pop.
  - Pop occurs when out_valid & out_ready.
  - out_valid = (count != 0).
  - out_* driven from the FIFO head entry (registered storage, not the input).
  - Overflow is impossible by construction of in_ready.
- Latency:
  - An element that completes a word is visible on out_* the cycle after acceptance, when the FIFO was empty.
  - A held hi lane is visible only after its pair, in_last, or a format switch arrives.
- Throughput: with DEPTH=4 and out_ready held high, one input element per cycle is sustained for any format mix.
- Output stability: while out_valid & !out_ready, out_data, out_fmt, out_lane_mask and out_last hold constant.
- partial_pending = (state==HALF), registered.
- Reset (rst high at a clock edge):
  - state EMPTY, hold_reg 0, count 0, pointers 0.
  - out_valid 0, out_data 0, out_fmt FP32, out_lane_mask 2'b00, out_last 0, partial_pending 0.
  - in_ready is 0 while rst is high.
  - A held bf16 or queued words are discarded when reset is asserted mid-stream.
  - in_ready = 1 the first cycle after rst deasserts.
- No input-side flush port: a dangling hi lane is emitted only by in_last or a format switch.

Test Plan:
1. Reset, then FP32 in_data=32'h3F800000 with last=1 and out_ready=1 -> next cycle out_data=32'h3F800000, fmt=FP32, mask=11, last=1; out_valid=1 for exactly one cycle.
2. FP16 pair 16'h3F80 then 16'h4000 (last on the second) -> single word 32'h3F804000, fmt=FP16, mask=11, last=1; partial_pending=1 only between the two accepts.
3. Odd group: FP16 16'h3F80, 16'h4000, 16'h4040(last) -> words 32'h3F804000 (mask 11, last 0), then 32'h40400000 (mask 10, last 1).
4. Format switch: FP16 16'hBF80, then FP32 32'h40490FDB(last) -> 32'hBF800000 (FP16, mask 10, last 0), then 32'h40490FDB (FP32, mask 11, last 1), in order.
5. Backpressure: out_ready=0 while 8 FP32 words are offered -> exactly 4 accepted and in_ready=0; out_* stable; release out_ready -> 4 words drain in order, and in_ready returns the cycle after count drops below DEPTH.
6. Reset mid-stream: hold FP16 16'h1234 in HALF with 2 words queued, assert rst for 1 cycle -> out_valid=0, partial_pending=0, nothing emitted; next FP16 pair packs fresh with no stale 16'h1234.
